serial_cfg_loader: RTL and testbench
====================================

Name: serial_cfg_loader

Overview:
- Parametrised serial configuration loader for clock synthesisers and other 3-wire (sclk/data/strobe) config devices, such as the IDT video clock chip.
- Shifts a CFG_WIDTH-bit word out with a programmable bit rate and bit order, then pulses strobe to latch it.
- Optionally auto-loads a default word after reset. Accepts run-time reprogramming (e.g. pixel clock change from the SoC) through a start/busy/done handshake.
- Sits in the top level between the CPU/GPIO domain and the config pins, all on one clock.

Parameters:
- CFG_WIDTH, 24, number of config bits shifted per load (2..64).
- CLK_DIV, 1, clk cycles per sclk half-period (>=1).
- LSB_FIRST, 1, 1: bit 0 is shifted first; 0: bit CFG_WIDTH-1 is shifted first.
- STROBE_LEN, 2, strobe high time in sclk half-periods (>=1).
- AUTO_START, 1, 1: perform one load of DEFAULT_CFG right after reset deasserts.
- DEFAULT_CFG, 0, CFG_WIDTH-bit word used by the auto-start load.

Ports:
- clk  in  1  block clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  load request; sampled every cycle.
- cfg_data  in  CFG_WIDTH  word to load; captured only in the cycle start is accepted.
- busy  out  1  high while a load is in progress.
- done  out  1  one-cycle pulse when a load completes.
- cfg_sclk  out  1  serial clock to the device.
- cfg_data_o  out  1  serial data to the device.
- cfg_strobe  out  1  latch strobe to the device.

Behaviour:
- All outputs are registered.
- Reset:
  - At the edge where reset=1: state=IDLE; busy, done, cfg_sclk, cfg_data_o, cfg_strobe = 0; divider and bit counters = 0.
  - Applies at any point mid-load: the load is abandoned with no strobe.
  - start is ignored while reset=1.
- Auto-start: if AUTO_START=1, the first cycle with reset=0 after reset acts as an accepted start with DEFAULT_CFG, regardless of start/cfg_data. It repeats after every reset.
- States:
  - IDLE.
  - SHIFT: phase LO/HI per bit.
  - STROBE.
- Accept: start=1 while state==IDLE at edge T.
  - Shift register <= cfg_data (or DEFAULT_CFG for auto-start).
  - From T+1: busy=1; state=SHIFT; cfg_sclk=0; cfg_data_o=first bit.
- start while busy=1 is ignored; it is neither queued nor an error.
- Tick: the divider counts 0..CLK_DIV-1 and ticks when it reaches CLK_DIV-1. Each state/phase lasts exactly CLK_DIV cycles per half-period.
- Bit i (i=0..CFG_WIDTH-1), with D=CLK_DIV:
  - cfg_data_o holds the bit for cycles T+1+2iD .. T+(2i+2)D.
  - cfg_sclk=0 for the first D cycles and 1 for the second D cycles.
  - Data therefore changes only while cfg_sclk is low, giving >=D cycles of setup and hold.
- Bit order:
  - LSB_FIRST=1: bit i = cfg[i].
  - LSB_FIRST=0: bit i = cfg[CFG_WIDTH-1-i].
- After the last bit's HI phase, state=STROBE: cfg_sclk=0, cfg_data_o=0, cfg_strobe=1 for STROBE_LEN*D cycles.
- On STROBE expiry, at the same edge: state=IDLE, busy=0, cfg_strobe=0, done=1 for one cycle.
- Total busy time = (2*CFG_WIDTH + STROBE_LEN)*D cycles.
- Back-to-back: start=1 in the cycle done=1 is accepted, because state is already IDLE. busy reasserts the next cycle, leaving a one-cycle busy-low gap.
- cfg_data changes after acceptance have no effect on the load in progress.
- Counter widths:
  - Bit counter: $clog2(CFG_WIDTH) bits.
  - Divider: $clog2(CLK_DIV+1) bits.
  - Strobe counter: $clog2(STROBE_LEN+1) bits.
  - None of these counters wrap inside a load; each is cleared at every state transition.

Decomposition:
- Shared header serial_cfg_loader_defs.vh: state encodings (IDLE, SHIFT, STROBE) and the phase encodings (LO, HI).
- One natural sub-module, serial_cfg_tick: the CLK_DIV half-period divider with synchronous clear, producing the tick output.
- The state machine, shift register and output registers stay in serial_cfg_loader.

Test Plan:
1. Reset release, AUTO_START=1, DEFAULT_CFG=24'h0A5C31, D=1:
   - busy rises 1 cycle after reset falls.
   - 24 sclk rising edges with data LSB-first 1,0,0,0,1,1,0,0,...
   - strobe high 2 cycles; done pulses; busy high for exactly 50 cycles.
2. AUTO_START=0, LSB_FIRST=0, CLK_DIV=3, CFG_WIDTH=8, start with cfg_data=8'hC3:
   - Bits 1,1,0,0,0,0,1,1, each bit 6 cycles (sclk 3 low / 3 high).
   - strobe 6 cycles; busy 54 cycles.
3. start pulsed every cycle during a load with changing cfg_data:
   - The load in progress is unaffected.
   - Exactly one done pulse; a new load starts only at the cycle of done.
4. start held high continuously, D=1, W=24:
   - Loads repeat with a one-cycle busy-low gap, each exactly 50 cycles.
   - done pulses at a period of 51 cycles.
5. reset=1 asserted at bit 10 of a load:
   - Next edge: all outputs 0, no strobe.
   - After release, with AUTO_START=1, a complete fresh load of DEFAULT_CFG.
6. start asserted while reset=1:
   - Ignored; with AUTO_START=0, busy stays 0 after release until a new start.

Source files
------------

// File: rtl/serial_cfg_loader_pkg.sv
// Shared types for the serial configuration loader.
//   state_t : top-level load sequencer state (idle / shifting bits / strobing)
//   phase_t : half-period of the current bit while shifting (sclk low / high)
package serial_cfg_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_STROBE = 2'd2
  } state_t;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_t;

endpackage

// File: rtl/serial_cfg_loader_if.sv
// Request/handshake bundle between the CPU/GPIO side and the loader.
//   start    : load request (master -> loader)
//   cfg_data : word to load, captured when start is accepted
//   busy     : load in progress (loader -> master)
//   done     : one-cycle completion pulse (loader -> master)
interface serial_cfg_loader_if #(
  parameter int CFG_WIDTH = 24
);
  logic                 start;
  logic [CFG_WIDTH-1:0] cfg_data;
  logic                 busy;
  logic                 done;

  modport master (output start, cfg_data, input busy, done);
  modport slave  (input start, cfg_data, output busy, done);
endinterface

// File: rtl/serial_cfg_tick.sv
// Half-period divider: counts 0..CLK_DIV-1 and asserts tick on the last count.
//   clk   : block clock
//   reset : synchronous active-high reset
//   clr   : synchronous clear, holds the count at 0
//   tick  : high in the final cycle of each half-period
module serial_cfg_tick #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Wrapping on tick restarts the count for the next half-period, so every
  // phase and state lasts exactly CLK_DIV cycles without loader involvement.
  always_ff @(posedge clk) begin
    if (reset)             cnt <= '0;
    else if (clr || tick)  cnt <= '0;
    else                   cnt <= cnt + DW'(1);
  end
endmodule

// File: rtl/serial_cfg_loader.sv
// Serial configuration loader: shifts a CFG_WIDTH-bit word out on a 3-wire
// sclk/data/strobe interface, then pulses strobe to latch it.
//   clk        : block clock
//   reset      : synchronous active-high reset
//   bus        : start/cfg_data in, busy/done out (slave side)
//   cfg_sclk   : serial clock to the device
//   cfg_data_o : serial data to the device
//   cfg_strobe : latch strobe to the device
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start (or the pending auto-start after reset)
// ST_SHIFT  | shifting bits; PH_LO = sclk low (data change), PH_HI = sclk high
// ST_STROBE | strobe high for STROBE_LEN half-periods
module serial_cfg_loader
  import serial_cfg_loader_pkg::*;
#(
  parameter int                   CFG_WIDTH   = 24,
  parameter int                   CLK_DIV     = 1,
  parameter bit                   LSB_FIRST   = 1'b1,
  parameter int                   STROBE_LEN  = 2,
  parameter bit                   AUTO_START  = 1'b1,
  parameter logic [CFG_WIDTH-1:0] DEFAULT_CFG = '0
) (
  input  logic                clk,
  input  logic                reset,
  serial_cfg_loader_if.slave  bus,
  output logic                cfg_sclk,
  output logic                cfg_data_o,
  output logic                cfg_strobe
);
  localparam int BW = $clog2(CFG_WIDTH);
  localparam int SW = $clog2(STROBE_LEN + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(CFG_WIDTH - 1);
  localparam logic [SW-1:0] LAST_STRB = SW'(STROBE_LEN - 1);

  state_t               state_q, state_d;
  phase_t               phase_q, phase_d;
  logic [CFG_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [SW-1:0]        strb_q, strb_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sclk_q, sclk_d;
  logic                 data_q, data_d;
  logic                 strobe_q, strobe_d;
  logic                 auto_q, auto_d;
  logic                 tick;
  logic [CFG_WIDTH-1:0] load_word;
  logic [CFG_WIDTH-1:0] shifted;

  function automatic logic first_bit(input logic [CFG_WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[CFG_WIDTH-1];
  endfunction

  // Divider held cleared in IDLE so the first half-period starts aligned
  // to the acceptance edge.
  serial_cfg_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == ST_IDLE),
    .tick  (tick)
  );

  assign load_word = auto_q ? DEFAULT_CFG : bus.cfg_data;
  assign shifted   = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    strb_d   = strb_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sclk_d   = sclk_q;
    data_d   = data_q;
    strobe_d = strobe_q;
    auto_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // auto_q is only ever set for the first post-reset cycle
        if (auto_q || bus.start) begin
          state_d = ST_SHIFT;
          phase_d = PH_LO;
          shreg_d = load_word;
          bit_d   = '0;
          strb_d  = '0;
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
          data_d  = first_bit(load_word);
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (phase_q == PH_LO) begin
            phase_d = PH_HI;
            sclk_d  = 1'b1;
          end else if (bit_q == LAST_BIT) begin
            state_d  = ST_STROBE;
            phase_d  = PH_LO;
            bit_d    = '0;
            strb_d   = '0;
            sclk_d   = 1'b0;
            data_d   = 1'b0;
            strobe_d = 1'b1;
          end else begin
            phase_d = PH_LO;
            bit_d   = bit_q + BW'(1);
            sclk_d  = 1'b0;
            shreg_d = shifted;
            data_d  = first_bit(shifted);
          end
        end
      end
      ST_STROBE: begin
        if (tick) begin
          if (strb_q == LAST_STRB) begin
            state_d  = ST_IDLE;
            strb_d   = '0;
            busy_d   = 1'b0;
            strobe_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            strb_d = strb_q + SW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_LO;
      shreg_q  <= '0;
      bit_q    <= '0;
      strb_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      data_q   <= 1'b0;
      strobe_q <= 1'b0;
      auto_q   <= AUTO_START;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      strb_q   <= strb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      auto_q   <= auto_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign cfg_sclk   = sclk_q;
  assign cfg_data_o = data_q;
  assign cfg_strobe = strobe_q;
endmodule

// File: tb/tb_serial_cfg_loader.sv
// Directed bench for serial_cfg_loader. Two instances cover the two
// parameter sets: dut_a (W=24, D=1, LSB first, auto-start 0A5C31) and
// dut_b (W=8, D=3, MSB first, no auto-start). Observed output vector is
// {busy, done, cfg_sclk, cfg_data_o, cfg_strobe}.
module tb_serial_cfg_loader;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic sclk_a, data_a, strobe_a;
  logic sclk_b, data_b, strobe_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_cfg_loader_if #(.CFG_WIDTH(24)) bus_a ();
  serial_cfg_loader_if #(.CFG_WIDTH(8))  bus_b ();

  serial_cfg_loader #(
    .CFG_WIDTH(24), .CLK_DIV(1), .LSB_FIRST(1'b1), .STROBE_LEN(2),
    .AUTO_START(1'b1), .DEFAULT_CFG(24'h0A5C31)
  ) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a),
    .cfg_sclk(sclk_a), .cfg_data_o(data_a), .cfg_strobe(strobe_a)
  );

  serial_cfg_loader #(
    .CFG_WIDTH(8), .CLK_DIV(3), .LSB_FIRST(1'b0), .STROBE_LEN(2),
    .AUTO_START(1'b0), .DEFAULT_CFG(8'h00)
  ) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b),
    .cfg_sclk(sclk_b), .cfg_data_o(data_b), .cfg_strobe(strobe_b)
  );

  function automatic logic [4:0] obs(input bit sel);
    if (sel) return {bus_b.busy, bus_b.done, sclk_b, data_b, strobe_b};
    return {bus_a.busy, bus_a.done, sclk_a, data_a, strobe_a};
  endfunction

  task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic drive(input bit sel, input logic s, input logic [23:0] c);
    if (sel) begin
      bus_b.start = s; bus_b.cfg_data = c[7:0];
    end else begin
      bus_a.start = s; bus_a.cfg_data = c;
    end
  endtask

  // Called just before the acceptance edge. Checks every cycle of the load
  // against the timing model, including the done cycle. noise drives start
  // with random data while busy; at the done cycle start/cfg are set to
  // nxt_start/nxt_cfg. stop_k > 0 abandons the check after cycle stop_k.
  task automatic check_load(input bit sel, input logic [23:0] cfg,
                            input int w, input int d, input int sl,
                            input bit lsb, input bit noise, input bit nxt_start,
                            input logic [23:0] nxt_cfg, input int stop_k,
                            input string tag);
    int total;
    int i;
    logic ph, bi;
    logic [4:0] e;
    total = (2 * w + sl) * d;
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      if (k <= 2 * w * d) begin
        i  = (k - 1) / (2 * d);
        ph = (((k - 1) % (2 * d)) >= d);
        bi = lsb ? cfg[i] : cfg[w - 1 - i];
        e  = {1'b1, 1'b0, ph, bi, 1'b0};
      end else if (k <= total) begin
        e = 5'b10001;
      end else begin
        e = 5'b01000;
      end
      chk($sformatf("%s k=%0d", tag, k), obs(sel), e);
      if (stop_k != 0 && k == stop_k) return;
      if (k == total + 1) drive(sel, nxt_start, nxt_cfg);
      else if (noise)     drive(sel, 1'b1, 24'($urandom));
      else                drive(sel, 1'b0, 24'h0);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(1'b0, 1'b0, 24'h0);
    drive(1'b1, 1'b1, 24'hC3);  // start held during reset must be ignored
    repeat (3) @(negedge clk);
    chk("reset_a", obs(1'b0), 5'b00000);
    chk("reset_b_start_held", obs(1'b1), 5'b00000);

    // start during reset, then release with start low: no load on dut_b
    rst_b = 1'b0;
    drive(1'b1, 1'b0, 24'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("b_idle_after_rel k=%0d", k), obs(1'b1), 5'b00000);
    end

    // MSB-first, D=3, W=8 load of C3
    drive(1'b1, 1'b1, 24'hC3);
    check_load(1'b1, 24'hC3, 8, 3, 2, 1'b0, 1'b0, 1'b0, 24'h0, 0, "b_c3");
    @(negedge clk);
    chk("b_idle_after_load", obs(1'b1), 5'b00000);

    // auto-start of DEFAULT_CFG on dut_a reset release
    rst_a = 1'b0;
    check_load(1'b0, 24'h0A5C31, 24, 1, 2, 1'b1, 1'b0, 1'b0, 24'h0, 0, "a_auto");
    @(negedge clk);
    chk("a_idle_after_auto", obs(1'b0), 5'b00000);

    // start spammed with changing data during a load; next load only at done
    drive(1'b0, 1'b1, 24'h5A3C96);
    check_load(1'b0, 24'h5A3C96, 24, 1, 2, 1'b1, 1'b1, 1'b1, 24'hF0E1D2, 0, "a_noise");
    // start held continuously: back-to-back loads with one-cycle gap
    check_load(1'b0, 24'hF0E1D2, 24, 1, 2, 1'b1, 1'b1, 1'b1, 24'h13579B, 0, "a_b2b1");
    check_load(1'b0, 24'h13579B, 24, 1, 2, 1'b1, 1'b0, 1'b0, 24'h0, 0, "a_b2b2");
    @(negedge clk);
    chk("a_idle_after_b2b", obs(1'b0), 5'b00000);

    // reset at bit 10 of an auto-start load
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check_load(1'b0, 24'h0A5C31, 24, 1, 2, 1'b1, 1'b0, 1'b0, 24'h0, 21, "a_pre_abort");
    rst_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("a_abort k=%0d", k), obs(1'b0), 5'b00000);
    end
    rst_a = 1'b0;
    check_load(1'b0, 24'h0A5C31, 24, 1, 2, 1'b1, 1'b0, 1'b0, 24'h0, 0, "a_reload");
    @(negedge clk);
    chk("a_idle_end", obs(1'b0), 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
